// File: rtl/pu_slave_spi.sv
// SPI slave processing unit: double-buffered rx/tx word buffers between an
// external SPI master (mode 0, MSB first) and the PU data bus.
module pu_slave_spi #(
    parameter int DATA_WIDTH     = 32,
    parameter int ATTR_WIDTH     = 4,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int BUF_SIZE       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  signal_oe,
    input  logic                  signal_cycle,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  flag_overflow
);

    localparam int AW     = $clog2(BUF_SIZE);
    localparam int CW     = AW + 1;
    localparam int FRAMES = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int SBW    = $clog2(SPI_DATA_WIDTH + 1);
    localparam int FBW    = $clog2(FRAMES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cs_sr_q, cs_sr_d;
    logic [2:0]            sclk_sr_q, sclk_sr_d;
    logic [1:0]            mosi_sr_q, mosi_sr_d;
    logic [SBW-1:0]        bit_q, bit_d;
    logic [FBW-1:0]        frm_q, frm_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]         tx_rd_q, tx_rd_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]         commit_cnt_q, commit_cnt_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  rx_bank_q, rx_bank_d;
    logic                  tx_bank_q, tx_bank_d;
    logic                  swap_pend_q, swap_pend_d;
    logic                  ovf_q, ovf_d;
    logic                  commit_ovf_q, commit_ovf_d;
    logic                  rd_ovf_q, rd_ovf_d;

    logic [DATA_WIDTH-1:0] rx_mem_q [2][BUF_SIZE];
    logic [DATA_WIDTH-1:0] tx_mem_q [2][BUF_SIZE];

    logic                  cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic                  swap_now, rx_we, tx_we;
    logic [DATA_WIDTH-1:0] rx_wdata, tx_word;

    assign cs_fall   = cs_sr_q[2] & ~cs_sr_q[1];
    assign cs_rise   = ~cs_sr_q[2] & cs_sr_q[1];
    assign sclk_rise = ~sclk_sr_q[2] & sclk_sr_q[1];
    assign sclk_fall = sclk_sr_q[2] & ~sclk_sr_q[1];
    assign rx_wdata  = {rx_shift_q[DATA_WIDTH-2:0], mosi_sr_q[1]};
    assign tx_word   = (tx_rd_q < tx_cnt_q) ?
                       tx_mem_q[~tx_bank_q][tx_rd_q[AW-1:0]] : '0;
    assign swap_now  = (state_q == IDLE) && (signal_cycle || swap_pend_q);
    assign tx_we     = signal_wr && (wr_ptr_q < CW'(BUF_SIZE));
    assign miso          = tx_shift_q[DATA_WIDTH-1];
    assign flag_overflow = ovf_q;

    always_comb begin
        state_d      = state_q;
        cs_sr_d      = {cs_sr_q[1:0], cs};
        sclk_sr_d    = {sclk_sr_q[1:0], sclk};
        mosi_sr_d    = {mosi_sr_q[0], mosi};
        bit_d        = bit_q;
        frm_d        = frm_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_cnt_d     = rx_cnt_q;
        tx_rd_d      = tx_rd_q;
        ovf_d        = ovf_q;
        commit_cnt_d = commit_cnt_q;
        commit_ovf_d = commit_ovf_q;
        rx_we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = LOAD;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                tx_shift_d = tx_word;
                rx_cnt_d   = '0;
                bit_d      = '0;
                frm_d      = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = rx_wdata;
                    if (bit_q == SBW'(SPI_DATA_WIDTH - 1)) begin
                        bit_d = '0;
                        if (frm_q == FBW'(FRAMES - 1)) begin
                            frm_d = '0;
                            if (tx_rd_q < CW'(BUF_SIZE))
                                tx_rd_d = tx_rd_q + 1'b1;
                            if (rx_cnt_q < CW'(BUF_SIZE)) begin
                                rx_we    = 1'b1;
                                rx_cnt_d = rx_cnt_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            frm_d = frm_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                // Counters at zero on a falling edge mean a word just ended.
                if (sclk_fall) begin
                    if (bit_q == '0 && frm_q == '0)
                        tx_shift_d = tx_word;
                    else
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (cs_rise)
                    state_d = COMMIT;
            end
            COMMIT: begin
                commit_cnt_d = rx_cnt_q;
                commit_ovf_d = ovf_q;
                tx_shift_d   = '0;
                tx_rd_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        swap_pend_d = swap_pend_q;
        rx_bank_d   = rx_bank_q;
        tx_bank_d   = tx_bank_q;
        tx_cnt_d    = tx_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_ovf_d    = rd_ovf_q;
        wr_ptr_d    = tx_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (signal_oe && rd_ptr_q < rd_cnt_q)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (swap_now) begin
            swap_pend_d = 1'b0;
            rx_bank_d   = ~rx_bank_q;
            tx_bank_d   = ~tx_bank_q;
            tx_cnt_d    = wr_ptr_d;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            rd_cnt_d    = commit_cnt_q;
            rd_ovf_d    = commit_ovf_q;
        end else if (signal_cycle) begin
            swap_pend_d = 1'b1;
        end
    end

    always_comb begin
        data_out = '0;
        attr_out = '0;
        if (signal_oe) begin
            attr_out[1] = rd_ovf_q;
            if (rd_ptr_q < rd_cnt_q)
                data_out = rx_mem_q[~rx_bank_q][rd_ptr_q[AW-1:0]];
            else
                attr_out[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_we)
            rx_mem_q[rx_bank_q][rx_cnt_q[AW-1:0]] <= rx_wdata;
        if (tx_we)
            tx_mem_q[tx_bank_q][wr_ptr_q[AW-1:0]] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cs_sr_q      <= '0;
            sclk_sr_q    <= '0;
            mosi_sr_q    <= '0;
            bit_q        <= '0;
            frm_q        <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            tx_rd_q      <= '0;
            wr_ptr_q     <= '0;
            tx_cnt_q     <= '0;
            commit_cnt_q <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            rx_bank_q    <= 1'b0;
            tx_bank_q    <= 1'b0;
            swap_pend_q  <= 1'b0;
            ovf_q        <= 1'b0;
            commit_ovf_q <= 1'b0;
            rd_ovf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_sr_q      <= cs_sr_d;
            sclk_sr_q    <= sclk_sr_d;
            mosi_sr_q    <= mosi_sr_d;
            bit_q        <= bit_d;
            frm_q        <= frm_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_rd_q      <= swap_now ? '0 : tx_rd_d;
            wr_ptr_q     <= wr_ptr_d;
            tx_cnt_q     <= tx_cnt_d;
            commit_cnt_q <= swap_now ? '0 : commit_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            rx_bank_q    <= rx_bank_d;
            tx_bank_q    <= tx_bank_d;
            swap_pend_q  <= swap_pend_d;
            ovf_q        <= ovf_d;
            commit_ovf_q <= swap_now ? 1'b0 : commit_ovf_d;
            rd_ovf_q     <= rd_ovf_d;
        end
    end

endmodule
